// File: rtl/core_pkg.sv
// Shared pipeline types for the RV32I core: forwarding-select encoding and
// the per-stage destination tracking record used by hazard control.
package core_pkg;

  localparam int CORE_REG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic [CORE_REG_AW-1:0] rd;
    logic                   wen;
    logic                   load;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{rd: '0, wen: 1'b0, load: 1'b0};

  // The producer sitting in EX now is in MEM when the consumer reaches EX,
  // so an EX match selects the MEM result and a MEM match selects WB data.
  function automatic logic [1:0] fwd_sel(input logic match_ex, input logic match_mem);
    logic [1:0] sel;
    sel = FWD_REG;
    if (match_ex) begin
      sel = FWD_MEM;
    end else if (match_mem) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/alu_fwd_hazard_ctrl_fwd_match.sv
// Combinational comparator: does the tracked stage write the register the
// ID instruction reads? x0 never matches.
module fwd_match
  import core_pkg::*;
(
  input  stage_t                 stage_i,
  input  logic [CORE_REG_AW-1:0] rs_i,
  input  logic                   use_i,
  output logic                   match_o
);

  assign match_o = stage_i.wen && (stage_i.rd == rs_i) && (rs_i != '0) && use_i;

endmodule

// File: rtl/alu_fwd_hazard_ctrl.sv
// Hazard/forwarding control for the 5-stage core: tracks EX/MEM/WB destinations,
// registers operand forwarding selects into EX, raises load-use stall and branch flush.
module alu_fwd_hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wen,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count
);

  stage_t ex_q, ex_d;
  stage_t mem_q;
  stage_t wb_q;

  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [CORE_REG_AW-1:0] rs1_w, rs2_w;
  logic m_ex_rs1, m_ex_rs2, m_mem_rs1, m_mem_rs2;
  logic capture;

  assign rs1_w = CORE_REG_AW'(id_rs1);
  assign rs2_w = CORE_REG_AW'(id_rs2);

  fwd_match u_match_ex_rs1 (
    .stage_i (ex_q),
    .rs_i    (rs1_w),
    .use_i   (id_use_rs1),
    .match_o (m_ex_rs1)
  );

  fwd_match u_match_ex_rs2 (
    .stage_i (ex_q),
    .rs_i    (rs2_w),
    .use_i   (id_use_rs2),
    .match_o (m_ex_rs2)
  );

  fwd_match u_match_mem_rs1 (
    .stage_i (mem_q),
    .rs_i    (rs1_w),
    .use_i   (id_use_rs1),
    .match_o (m_mem_rs1)
  );

  fwd_match u_match_mem_rs2 (
    .stage_i (mem_q),
    .rs_i    (rs2_w),
    .use_i   (id_use_rs2),
    .match_o (m_mem_rs2)
  );

  // A taken branch kills the dependent anyway, so it suppresses the stall.
  assign flush   = ex_branch_taken;
  assign stall   = id_valid && !ex_branch_taken && ex_q.load && (m_ex_rs1 || m_ex_rs2);
  assign capture = id_valid && !stall && !flush;

  always_comb begin
    ex_d    = STAGE_BUBBLE;
    fwd_a_d = FWD_REG;
    fwd_b_d = FWD_REG;
    cnt_d   = cnt_q;
    if (capture) begin
      ex_d.rd   = CORE_REG_AW'(id_rd);
      ex_d.wen  = id_reg_wen;
      ex_d.load = id_mem_read;
      fwd_a_d   = fwd_sel(m_ex_rs1, m_mem_rs1);
      fwd_b_d   = fwd_sel(m_ex_rs2, m_mem_rs2);
    end
    if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= STAGE_BUBBLE;
      mem_q   <= STAGE_BUBBLE;
      wb_q    <= STAGE_BUBBLE;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // WB contents and the MEM load flag have no consumer here: the regfile
  // bypasses same-cycle WB writes, and a MEM load forwards like any producer.
  logic unused_stage;
  assign unused_stage = ^{wb_q, mem_q.load};

  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_alu_fwd_hazard_ctrl.sv
// Self-checking bench for alu_fwd_hazard_ctrl: per-scenario tasks with an
// expectation queue, plus a narrow-counter instance for saturation.
module tb_alu_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_wen, id_mem_read;
  logic       ex_branch_taken;

  logic        stall, flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count;

  logic        stall_s, flush_s;
  logic [1:0]  fwd_a_s, fwd_b_s;
  logic [1:0]  stall_count_s;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_reg_wen      (id_reg_wen),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush           (flush),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall_count     (stall_count)
  );

  alu_fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_reg_wen      (id_reg_wen),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall_s),
    .flush           (flush_s),
    .fwd_a_sel       (fwd_a_s),
    .fwd_b_sel       (fwd_b_s),
    .stall_count     (stall_count_s)
  );

  // Called just after a falling edge: drives ID, checks stall/flush in the same
  // cycle, then checks the selects registered at the following rising edge.
  task automatic issue(input string name, input logic v,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wen, input logic ld,
                       input logic br,
                       input logic es, input logic ef,
                       input logic [1:0] ea, input logic [1:0] eb);
    exp_t e;
    exp_q.push_back('{stall: es, flush: ef, a: ea, b: eb});
    id_valid        = v;
    id_rs1          = rs1;
    id_use_rs1      = u1;
    id_rs2          = rs2;
    id_use_rs2      = u2;
    id_rd           = rd;
    id_reg_wen      = wen;
    id_mem_read     = ld;
    ex_branch_taken = br;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (stall !== e.stall) begin
      errors++;
      $display("FAIL %s stall: got %b want %b", name, stall, e.stall);
    end
    checks++;
    if (flush !== e.flush) begin
      errors++;
      $display("FAIL %s flush: got %b want %b", name, flush, e.flush);
    end
    @(posedge clk);
    #1;
    checks++;
    if (fwd_a_sel !== e.a) begin
      errors++;
      $display("FAIL %s fwd_a_sel: got %0d want %0d", name, fwd_a_sel, e.a);
    end
    checks++;
    if (fwd_b_sel !== e.b) begin
      errors++;
      $display("FAIL %s fwd_b_sel: got %0d want %0d", name, fwd_b_sel, e.b);
    end
    @(negedge clk);
  endtask

  task automatic nops(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      issue(name, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b0, 2'd0, 2'd0);
    end
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    id_valid        = 1'b0;
    id_use_rs1      = 1'b0;
    id_use_rs2      = 1'b0;
    id_reg_wen      = 1'b0;
    id_mem_read     = 1'b0;
    ex_branch_taken = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (stall_count !== 16'd0 || stall_count_s !== 2'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d/%0d want 0/0", stall_count, stall_count_s);
    end
    nops("reset_idle", 3);
  endtask

  task automatic test_fwd_ex();
    issue("ex_add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    issue("ex_sub", 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
    nops("ex_drain", 3);
  endtask

  task automatic test_fwd_mem();
    issue("mem_add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    nops("mem_gap", 1);
    issue("mem_use", 1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
    nops("mem_drain", 3);
    issue("x0_add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    nops("x0_gap", 1);
    issue("x0_use", 1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    nops("x0_drain", 3);
  endtask

  task automatic test_load_use();
    do_reset();
    issue("lu_lw",   1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    issue("lu_stall", 1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    issue("lu_go",   1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0);
    checks++;
    if (stall_count !== 16'd1) begin
      errors++;
      $display("FAIL lu_count: got %0d want 1", stall_count);
    end
    nops("lu_drain", 3);
  endtask

  task automatic test_dual_producer();
    issue("dual_add",  1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    issue("dual_addi", 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
    issue("dual_use",  1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
    nops("dual_drain", 3);
  endtask

  task automatic test_branch_flush();
    issue("br_lw",  1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    issue("br_dep", 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    // A consumer of the flushed instruction's rd would forward or stall had it entered EX.
    issue("br_after", 1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    nops("br_drain", 3);
  endtask

  task automatic test_saturate();
    logic [1:0] want_s;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      issue("sat_lw",    1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
      issue("sat_stall", 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
      issue("sat_go",    1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
      want_s = (k >= 3) ? 2'd3 : 2'(k);
      checks++;
      if (stall_count_s !== want_s) begin
        errors++;
        $display("FAIL sat_count_w2 k=%0d: got %0d want %0d", k, stall_count_s, want_s);
      end
      checks++;
      if (stall_count !== 16'(k)) begin
        errors++;
        $display("FAIL sat_count_w16 k=%0d: got %0d want %0d", k, stall_count, k);
      end
    end
    nops("sat_drain", 3);
  endtask

  task automatic test_reset_mid_stall();
    issue("rms_lw", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    rst = 1'b1;
    issue("rms_stall", 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    rst = 1'b0;
    issue("rms_after", 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    checks++;
    if (stall_count !== 16'd0) begin
      errors++;
      $display("FAIL rms_count: got %0d want 0", stall_count);
    end
    nops("rms_drain", 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    id_valid        = 1'b0;
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    id_rd           = 5'd0;
    id_use_rs1      = 1'b0;
    id_use_rs2      = 1'b0;
    id_reg_wen      = 1'b0;
    id_mem_read     = 1'b0;
    ex_branch_taken = 1'b0;
    @(negedge clk);
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_dual_producer();
    test_branch_flush();
    test_saturate();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
